// File: rtl/ms_cfg_sequencer.sv
// Round-robin sequencer: serialises 16-bit config writes into two master byte beats,
// waits for an XOR checksum acknowledge from the slave and then commits the word.
module ms_cfg_sequencer #(
    parameter int NUM_REQ     = 2,
    parameter int DATA_W      = 8,
    parameter int SEL_W       = 4,
    parameter int CFG_W       = 16,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
    input  logic [NUM_REQ*CFG_W-1:0]   req_data,
    output logic [DATA_W-1:0]          ma_send_data,
    output logic [SEL_W-1:0]           ma_sel,
    output logic                       ma_enable,
    input  logic [DATA_W-1:0]          sl_send_data,
    input  logic                       sl_valid,
    output logic [CFG_W-1:0]           config_data,
    output logic                       config_valid,
    output logic                       err_timeout,
    output logic                       err_nack,
    output logic                       busy,
    output logic [2:0]                 grant_id
);

    typedef enum logic [2:0] {
        IDLE, SEND_LO, SEND_HI, WAIT_ACK, COMMIT, ERR_TO, ERR_NACK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CFG_W-1:0]    word_q, word_d;
    logic [DATA_W-1:0]   ma_data_q, ma_data_d;
    logic [SEL_W-1:0]    ma_sel_q, ma_sel_d;
    logic                ma_en_q, ma_en_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic                cfg_vld_q, cfg_vld_d;
    logic                err_to_q, err_to_d;
    logic                err_nack_q, err_nack_d;
    logic                busy_q, busy_d;

    logic                win_found;
    logic [2:0]          win_idx;
    logic [NUM_REQ-1:0]  win_oh;
    logic [SEL_W-1:0]    win_sel;
    logic [CFG_W-1:0]    win_word;
    logic [DATA_W-1:0]   csum;
    logic                timeout_hit;

    // Search starts one past the last winner so a held request cannot starve others.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = idx[2:0];
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            win_oh[j] = (state_q == IDLE) && win_found && (win_idx == 3'(j));
        end
        win_sel  = req_sel[int'(win_idx)*SEL_W +: SEL_W];
        win_word = req_data[int'(win_idx)*CFG_W +: CFG_W];
    end

    assign req_ready   = win_oh;
    assign csum        = word_q[DATA_W-1:0] ^ word_q[CFG_W-1:DATA_W];
    assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= 9'(ACK_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        word_d     = word_q;
        cfg_d      = cfg_q;
        ma_sel_d   = ma_sel_q;
        ma_data_d  = '0;
        ma_en_d    = 1'b0;
        cfg_vld_d  = 1'b0;
        err_to_d   = 1'b0;
        err_nack_d = 1'b0;
        case (state_q)
            IDLE: begin
                ma_sel_d = '0;
                if (win_found) begin
                    sel_d     = win_sel;
                    word_d    = win_word;
                    ptr_d     = win_idx;
                    grant_d   = win_idx;
                    ma_en_d   = 1'b1;
                    ma_sel_d  = win_sel;
                    ma_data_d = win_word[DATA_W-1:0];
                    state_d   = SEND_LO;
                end
            end
            SEND_LO: begin
                ma_en_d   = 1'b1;
                ma_sel_d  = sel_q;
                ma_data_d = word_q[CFG_W-1:DATA_W];
                state_d   = SEND_HI;
            end
            SEND_HI: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_d = cnt_q + 8'd1;
                // A response on the timeout cycle still counts as an answer.
                if (sl_valid) begin
                    if (sl_send_data == csum) begin
                        cfg_d     = word_q;
                        cfg_vld_d = 1'b1;
                        state_d   = COMMIT;
                    end else begin
                        err_nack_d = 1'b1;
                        state_d    = ERR_NACK;
                    end
                end else if (timeout_hit) begin
                    err_to_d = 1'b1;
                    state_d  = ERR_TO;
                end
            end
            default: begin
                ma_sel_d = '0;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= 3'(NUM_REQ - 1);
            grant_q    <= '0;
            sel_q      <= '0;
            word_q     <= '0;
            cfg_q      <= '0;
            ma_sel_q   <= '0;
            ma_data_q  <= '0;
            ma_en_q    <= 1'b0;
            cfg_vld_q  <= 1'b0;
            err_to_q   <= 1'b0;
            err_nack_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            word_q     <= word_d;
            cfg_q      <= cfg_d;
            ma_sel_q   <= ma_sel_d;
            ma_data_q  <= ma_data_d;
            ma_en_q    <= ma_en_d;
            cfg_vld_q  <= cfg_vld_d;
            err_to_q   <= err_to_d;
            err_nack_q <= err_nack_d;
            busy_q     <= busy_d;
        end
    end

    assign ma_send_data = ma_data_q;
    assign ma_sel       = ma_sel_q;
    assign ma_enable    = ma_en_q;
    assign config_data  = cfg_q;
    assign config_valid = cfg_vld_q;
    assign err_timeout  = err_to_q;
    assign err_nack     = err_nack_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;

endmodule

// File: tb/tb_ms_cfg_sequencer.sv
// Randomised bench for ms_cfg_sequencer against a transaction-level reference model.
module tb_ms_cfg_sequencer;

    localparam int NUM_REQ     = 2;
    localparam int DATA_W      = 8;
    localparam int SEL_W       = 4;
    localparam int CFG_W       = 16;
    localparam int ACK_TIMEOUT = 15;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*SEL_W-1:0] req_sel = '0;
    logic [NUM_REQ*CFG_W-1:0] req_data = '0;
    logic [DATA_W-1:0]        ma_send_data;
    logic [SEL_W-1:0]         ma_sel;
    logic                     ma_enable;
    logic [DATA_W-1:0]        sl_send_data = '0;
    logic                     sl_valid = 1'b0;
    logic [CFG_W-1:0]         config_data;
    logic                     config_valid;
    logic                     err_timeout;
    logic                     err_nack;
    logic                     busy;
    logic [2:0]               grant_id;

    ms_cfg_sequencer #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SEL_W(SEL_W),
        .CFG_W(CFG_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_data(req_data),
        .ma_send_data(ma_send_data), .ma_sel(ma_sel), .ma_enable(ma_enable),
        .sl_send_data(sl_send_data), .sl_valid(sl_valid),
        .config_data(config_data), .config_valid(config_valid),
        .err_timeout(err_timeout), .err_nack(err_nack),
        .busy(busy), .grant_id(grant_id)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: last served requester and committed word.
    int          last_srv = NUM_REQ - 1;
    logic [15:0] cfg_m    = '0;
    logic [15:0] d_arr [NUM_REQ];
    logic [3:0]  s_arr [NUM_REQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] mask);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (last_srv + k) % NUM_REQ;
            if (mask[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input logic [NUM_REQ-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_sel[i*SEL_W +: SEL_W]  = s_arr[i];
            req_data[i*CFG_W +: CFG_W] = d_arr[i];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_men"},   32'(ma_enable),    32'd0);
        check({tag, "_msel"},  32'(ma_sel),       32'd0);
        check({tag, "_mdat"},  32'(ma_send_data), 32'd0);
        check({tag, "_cvld"},  32'(config_valid), 32'd0);
        check({tag, "_eto"},   32'(err_timeout),  32'd0);
        check({tag, "_enack"}, 32'(err_nack),     32'd0);
        check({tag, "_cfg"},   32'(config_data),  32'(cfg_m));
    endtask

    // Starts and ends on a negedge with the DUT idle. ack_at > ACK_TIMEOUT means no ack;
    // rst_at != 0 pulses reset on that WAIT_ACK cycle.
    task automatic txn(input logic [NUM_REQ-1:0] mask, input bit hold, input int ack_at,
                       input bit ack_ok, input logic [7:0] bad_val, input int rst_at);
        int w;
        logic [15:0] wd;
        logic [3:0] ws;
        logic [7:0] cs;
        logic [NUM_REQ-1:0] exp_rdy;
        bit done, acked, aborted;
        drive_reqs(mask);
        sl_valid = 1'b0;
        #1;
        w = pick(mask);
        exp_rdy = '0;
        exp_rdy[w] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy_pre", 32'(busy), 32'd0);
        wd = d_arr[w];
        ws = s_arr[w];
        cs = wd[7:0] ^ wd[15:8];
        last_srv = w;

        @(negedge clk);
        if (!hold) req_valid = '0;
        check("lo_en",    32'(ma_enable),    32'd1);
        check("lo_sel",   32'(ma_sel),       32'(ws));
        check("lo_data",  32'(ma_send_data), 32'(wd[7:0]));
        check("grant",    32'(grant_id),     32'(w));
        check("busy_lo",  32'(busy),         32'd1);
        check("rdy_busy", 32'(req_ready),    32'd0);
        sl_valid = 1'($urandom_range(0, 1));
        sl_send_data = cs;

        @(negedge clk);
        check("hi_en",   32'(ma_enable),    32'd1);
        check("hi_sel",  32'(ma_sel),       32'(ws));
        check("hi_data", 32'(ma_send_data), 32'(wd[15:8]));
        sl_valid = 1'($urandom_range(0, 1));
        sl_send_data = cs;

        @(negedge clk);
        done = 0; acked = 0; aborted = 0;
        for (int k = 1; k <= ACK_TIMEOUT && !done; k++) begin
            check("wait_en",   32'(ma_enable),    32'd0);
            check("wait_data", 32'(ma_send_data), 32'd0);
            check("wait_sel",  32'(ma_sel),       32'(ws));
            check("wait_cvld", 32'(config_valid), 32'd0);
            check("wait_eto",  32'(err_timeout),  32'd0);
            check("wait_busy", 32'(busy),         32'd1);
            if (k == rst_at) begin
                rst = 1'b1;
                sl_valid = 1'b0;
                req_valid = '0;
                @(negedge clk);
                rst = 1'b0;
                last_srv = NUM_REQ - 1;
                cfg_m = '0;
                check_idle("rst_abort");
                check("rst_grant", 32'(grant_id),  32'd0);
                check("rst_rdy",   32'(req_ready), 32'd0);
                done = 1;
                aborted = 1;
            end else begin
                if (k == ack_at) begin
                    sl_valid = 1'b1;
                    sl_send_data = ack_ok ? cs : ((bad_val == cs) ? ~cs : bad_val);
                    acked = 1;
                    done = 1;
                end else begin
                    sl_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!aborted) begin
            if (acked && ack_ok) cfg_m = wd;
            check("out_cvld",  32'(config_valid), 32'(acked && ack_ok));
            check("out_enack", 32'(err_nack),     32'(acked && !ack_ok));
            check("out_eto",   32'(err_timeout),  32'(!acked));
            check("out_cfg",   32'(config_data),  32'(cfg_m));
            check("out_busy",  32'(busy),         32'd1);
            sl_valid = 1'($urandom_range(0, 1));
            sl_send_data = cs;
            @(negedge clk);
            sl_valid = 1'b0;
            check_idle("idle");
            check("idle_grant", 32'(grant_id), 32'(w));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] m;
        int aa;
        for (int i = 0; i < NUM_REQ; i++) begin
            d_arr[i] = 16'($urandom());
            s_arr[i] = 4'($urandom());
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_grant", 32'(grant_id),  32'd0);
        check("reset_rdy",   32'(req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Both requesters held from reset: expect strict alternation.
        for (int t = 0; t < 4; t++) begin
            txn(2'b11, 1'b1, $urandom_range(1, 3), 1'b1, 8'h00, 0);
            check("arb_order", 32'(grant_id), 32'(t % 2));
        end

        d_arr[0] = 16'hA55A; s_arr[0] = 4'h3;
        txn(2'b01, 1'b0, 1, 1'b1, 8'h00, 0);
        check("single_cfg", 32'(config_data), 32'h0000A55A);

        d_arr[0] = 16'h1234;
        txn(2'b01, 1'b0, 3, 1'b0, 8'h00, 0);
        check("nack_keep", 32'(config_data), 32'h0000A55A);

        txn(2'b10, 1'b0, ACK_TIMEOUT + 1, 1'b1, 8'h00, 0);
        txn(2'b10, 1'b0, ACK_TIMEOUT, 1'b1, 8'h00, 0);

        txn(2'b01, 1'b0, 0, 1'b1, 8'h00, 5);
        sl_valid = 1'b1;
        sl_send_data = d_arr[0][7:0] ^ d_arr[0][15:8];
        @(negedge clk);
        sl_valid = 1'b0;
        check_idle("idle_ack");
        txn(2'b11, 1'b0, 2, 1'b1, 8'h00, 0);
        check("post_rst_grant", 32'(grant_id), 32'd0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                d_arr[i] = 16'($urandom());
                s_arr[i] = 4'($urandom());
            end
            m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            aa = $urandom_range(1, ACK_TIMEOUT + 2);
            txn(m, 1'($urandom_range(0, 1)), aa, ($urandom_range(0, 3) != 0),
                8'($urandom()), 0);
        end
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ms_cfg_sequencer.md
Name: ms_cfg_sequencer

Overview:
Sequences 16-bit configuration writes from several requesters onto the shared 8-bit master interface, then commits the value to the target configuration register. A round-robin arbiter grants one requester at a time. The granted word is sent as two byte beats on ma_send_data/ma_sel/ma_enable. The block then waits for a checksum acknowledge from the slave interface before updating config_data. It sits between the software/config requesters and the master_if/slave_if/target_if datapath.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 8, master/slave byte width
SEL_W, 4, master select width
CFG_W, 16, config word width (fixed 2*DATA_W)
ACK_TIMEOUT, 15, max WAIT_ACK cycles before timeout (1..255)

Ports:
clk  in  1  system clock, 20 ns period
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester accept
req_sel  in  NUM_REQ*SEL_W  packed target select, requester i at [i*SEL_W +: SEL_W]
req_data  in  NUM_REQ*CFG_W  packed config word, requester i at [i*CFG_W +: CFG_W]
ma_send_data  out  DATA_W  master byte beat
ma_sel  out  SEL_W  master select
ma_enable  out  1  master beat strobe
sl_send_data  in  DATA_W  slave acknowledge byte
sl_valid  in  1  slave acknowledge strobe
config_data  out  CFG_W  committed target config word
config_valid  out  1  one-cycle pulse on commit
err_timeout  out  1  one-cycle pulse, no ack in time
err_nack  out  1  one-cycle pulse, ack checksum mismatch
busy  out  1  high in every state except IDLE
grant_id  out  3  index of the current or last granted requester

Behaviour:
- Reset: all outputs 0: ma_send_data, ma_sel, ma_enable, config_data, config_valid, err_*, req_ready, grant_id, busy. State = IDLE. Wait counter = 0. RR pointer = NUM_REQ-1, so requester 0 wins first.
- Reset mid-transaction: abort immediately. No commit, no error pulse. The captured word is discarded.
- Arbitration, IDLE only:
  - Search starts at pointer+1 with wrap; the first asserted req_valid wins.
  - req_ready is high only for the winner (combinational from req_valid and state). All other req_ready bits are 0. All req_ready bits are 0 outside IDLE.
  - A handshake (valid & ready) captures sel and data, sets pointer = winner and grant_id = winner, and moves to SEND_LO.
- FSM, all outputs registered:
  - SEND_LO (1 cycle): ma_enable=1, ma_sel=sel, ma_send_data=data[7:0].
  - SEND_HI (1 cycle): ma_enable=1, ma_sel=sel, ma_send_data=data[15:8].
  - WAIT_ACK: ma_enable=0, ma_sel held, ma_send_data=0.
    - Counter increments each cycle.
    - sl_valid with sl_send_data == data[7:0]^data[15:8] goes to COMMIT.
    - sl_valid with any other value goes to ERR_NACK.
    - Counter reaching ACK_TIMEOUT without sl_valid goes to ERR_TO.
    - If sl_valid arrives on the same cycle as the timeout, sl_valid wins.
  - COMMIT (1 cycle): config_data <= captured word, config_valid=1, then IDLE.
  - ERR_TO / ERR_NACK (1 cycle): the matching err pulse; config_data unchanged; then IDLE.
- Timing: handshake in cycle T gives ma_enable high in T+1 and T+2. sl_valid is sampled from T+3 onward. An ack sampled in cycle K gives config_valid and the new config_data visible in K+1, and IDLE with req_ready possible in K+2.
- Outside WAIT_ACK: sl_valid is ignored.
- Continuously held request: a requester keeping req_valid high is served again only after every other asserting requester has been served once (fairness).
- ma_sel returns to 0 in IDLE.
- config_data holds its value between commits.

Test Plan:
- Single write: requester 0 sends sel=4'h3, data=16'hA55A. Expect beats 8'h5A then 8'hA5, with ma_sel=3 on both. Ack 8'hFF at T+3 -> config_data=16'hA55A and config_valid pulse at T+4.
- Arbitration: both requesters valid from reset. Expect order 0,1,0,1 over four transactions, with grant_id matching. req_ready is never high for both in the same cycle.
- Nack: data=16'h1234, ack 8'h00 (expected 8'h26) -> err_nack pulse. config_data keeps its previous value; no config_valid.
- Timeout: ACK_TIMEOUT=15, no sl_valid -> err_timeout pulses exactly 16 cycles after SEND_HI. busy drops the next cycle.
- Ack on the timeout cycle: sl_valid with the correct checksum on the 15th WAIT_ACK cycle -> commit; no err_timeout.
- Reset during WAIT_ACK: rst high for 1 cycle -> all outputs 0 next cycle and config_data=0. A later ack with sl_valid in IDLE is ignored. Requester 0 is granted first afterward.
